// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared encodings for the SRAM arbiter (states, ops, port ids)
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT0  = 2'b01,
        GRANT1  = 2'b10,
        RELEASE = 2'b11
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/sram_arb_pick.sv
// rtl/sram_arb_pick.sv - winner selection; SRAM_ARB_RR_EN selects round-robin, else fixed priority
module sram_arb_pick
    import sram_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_port
);

`ifdef SRAM_ARB_RR_EN
    // Round-robin: on a tie the port that was not granted last wins.
    always_comb begin
        grant_valid = req0 | req1;
        if (req0 && req1) begin
            grant_port = (last_grant == PORT1) ? PORT0 : PORT1;
        end else begin
            grant_port = req0 ? PORT0 : PORT1;
        end
    end
`else
    // Fixed priority: the data port always beats the fetch port.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        grant_valid = req0 | req1;
        grant_port  = req0 ? PORT0 : PORT1;
    end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port SRAM controller arbiter (data port / fetch port), SRAM_ARB_RR_EN enables round-robin
module sram_arbiter
    import sram_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m0_address,
    input  logic [31:0] m0_wdata,
    input  logic        m0_read,
    input  logic        m0_write,
    output logic [63:0] m0_rdata,
    output logic        m0_ready,
    input  logic [31:0] m1_address,
    input  logic        m1_read,
    output logic [63:0] m1_rdata,
    output logic        m1_ready,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    output logic        sram_read,
    output logic        sram_write,
    input  logic [63:0] sram_rdata,
    input  logic        sram_ready
);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] lat_address;
    logic [31:0] lat_wdata;
    op_t         lat_op;
    logic        abort_q;
    logic        req0;
    logic        req1;
    logic        last_grant;
    logic        grant_valid;
    logic        grant_port;
    logic        take_grant;
    logic        granted_req;

    assign req0       = m0_read | m0_write;
    assign req1       = m1_read;
    assign take_grant = (state == IDLE) && grant_valid;

    // Level of the request belonging to whichever port currently holds the grant.
    assign granted_req = (state == GRANT0) ? req0 : req1;

`ifdef SRAM_ARB_RR_EN
    logic last_grant_q;

    // Remember which port won the most recent arbitration.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= PORT1;
        end else if (take_grant) begin
            last_grant_q <= grant_port;
        end
    end

    assign last_grant = last_grant_q;
`else
    assign last_grant = PORT1;
`endif

    sram_arb_pick u_pick (
        .req0        (req0),
        .req1        (req1),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_port  (grant_port)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture the winning request so the SRAM command survives the requester dropping it.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_address <= '0;
            lat_wdata   <= '0;
            lat_op      <= OP_READ;
        end else if (take_grant) begin
            if (grant_port == PORT1) begin
                lat_address <= m1_address;
                lat_wdata   <= '0;
                lat_op      <= OP_READ;
            end else begin
                lat_address <= m0_address;
                lat_wdata   <= m0_wdata;
                lat_op      <= m0_write ? OP_WRITE : OP_READ;
            end
        end
    end

    // Sticky abort: once the granted requester lets go, its ready stays suppressed.
    always_ff @(posedge clk) begin
        if (rst) begin
            abort_q <= 1'b0;
        end else if (state == IDLE) begin
            abort_q <= 1'b0;
        end else if ((state == GRANT0 || state == GRANT1) && !granted_req) begin
            abort_q <= 1'b1;
        end
    end

    // Next-state and SRAM/requester outputs; ready and rdata pass straight through from the SRAM.
    always_comb begin
        state_nxt    = state;
        sram_address = '0;
        sram_wdata   = '0;
        sram_read    = 1'b0;
        sram_write   = 1'b0;
        m0_rdata     = '0;
        m0_ready     = 1'b0;
        m1_rdata     = '0;
        m1_ready     = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_nxt = (grant_port == PORT1) ? GRANT1 : GRANT0;
                end
            end
            GRANT0: begin
                sram_address = lat_address;
                sram_wdata   = lat_wdata;
                sram_read    = (lat_op == OP_READ);
                sram_write   = (lat_op == OP_WRITE);
                if (sram_ready) begin
                    m0_rdata  = sram_rdata;
                    m0_ready  = req0 & ~abort_q;
                    state_nxt = RELEASE;
                end
            end
            GRANT1: begin
                sram_address = lat_address;
                sram_wdata   = lat_wdata;
                sram_read    = (lat_op == OP_READ);
                sram_write   = (lat_op == OP_WRITE);
                if (sram_ready) begin
                    m1_rdata  = sram_rdata;
                    m1_ready  = req1 & ~abort_q;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - scoreboard bench for sram_arbiter with a behavioural arbitration model
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] m0_address = '0;
    logic [31:0] m0_wdata = '0;
    logic        m0_read = 1'b0;
    logic        m0_write = 1'b0;
    logic [63:0] m0_rdata;
    logic        m0_ready;
    logic [31:0] m1_address = '0;
    logic        m1_read = 1'b0;
    logic [63:0] m1_rdata;
    logic        m1_ready;
    logic [31:0] sram_address;
    logic [31:0] sram_wdata;
    logic        sram_read;
    logic        sram_write;
    logic [63:0] sram_rdata = '0;
    logic        sram_ready = 1'b0;

    sram_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .m0_address   (m0_address),
        .m0_wdata     (m0_wdata),
        .m0_read      (m0_read),
        .m0_write     (m0_write),
        .m0_rdata     (m0_rdata),
        .m0_ready     (m0_ready),
        .m1_address   (m1_address),
        .m1_read      (m1_read),
        .m1_rdata     (m1_rdata),
        .m1_ready     (m1_ready),
        .sram_address (sram_address),
        .sram_wdata   (sram_wdata),
        .sram_read    (sram_read),
        .sram_write   (sram_write),
        .sram_rdata   (sram_rdata),
        .sram_ready   (sram_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          write;
        logic [63:0] line;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int passed = 0;
    int total = 0;
    int force_dly = -1;
    int done_cnt[2] = '{0, 0};
    bit in_grant = 0;
    int cur_port = 0;

    localparam int M_IDLE = 0;
    localparam int M_BUSY = 1;
    localparam int M_REL  = 2;

    function automatic logic [63:0] line_of(input logic [31:0] a);
        if (a == 32'h0000_0100) return 64'h1122_3344_5566_7788;
        return {a * 32'h9E37_79B1, a ^ 32'h5A5A_A5A5};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // SRAM controller model: answers a held command after a delay, sometimes pulses ready while idle.
    initial begin : sram_model
        bit busy;
        int dly;
        busy = 0;
        dly = 0;
        forever begin
            @(posedge clk);
            #1;
            sram_ready = 1'b0;
            if (rst || !(sram_read || sram_write)) begin
                busy = 0;
                if (!rst && force_dly < 0 && $urandom_range(0, 7) == 0) begin
                    sram_ready = 1'b1;
                    sram_rdata = {$urandom, $urandom};
                end
            end else begin
                if (!busy) begin
                    busy = 1;
                    dly = (force_dly >= 0) ? force_dly : int'($urandom_range(0, 3));
                end
                if (dly == 0) begin
                    sram_ready = 1'b1;
                    sram_rdata = line_of(sram_address);
                    busy = 0;
                end else begin
                    dly--;
                end
            end
        end
    end

    // Monitor: predicts the winner from the request levels seen in IDLE and checks every cycle.
    int   mst = M_IDLE;
    bit   pend0 = 0;
    bit   pend1 = 0;
    int   lastg = 1;
    bit   aborted = 0;
    exp_t cur;

    always @(negedge clk) begin : monitor
        int   mst_start;
        logic r0;
        logic r1;
        logic cmd;
        r0 = m0_read | m0_write;
        r1 = m1_read;
        cmd = sram_read | sram_write;
        if (rst) begin
            mst = M_IDLE;
            pend0 = 0;
            pend1 = 0;
            q0.delete();
            q1.delete();
            lastg = 1;
            in_grant = 0;
        end else begin
            mst_start = mst;
            if (mst == M_IDLE) begin
                if (pend0 || pend1) begin
                    chk("grant_start", cmd, 1);
                    if (pend0 && pend1) begin
`ifdef SRAM_ARB_RR_EN
                        cur_port = (lastg == 1) ? 0 : 1;
`else
                        cur_port = 0;
`endif
                    end else begin
                        cur_port = pend0 ? 0 : 1;
                    end
                    lastg = cur_port;
                    cur = '{addr: 32'h0, wdata: 32'h0, write: 1'b0, line: 64'h0};
                    if (cur_port == 0 && q0.size() > 0) cur = q0.pop_front();
                    else if (cur_port == 1 && q1.size() > 0) cur = q1.pop_front();
                    else chk("scoreboard_empty", 1, 0);
                    aborted = 0;
                    in_grant = 1;
                    mst = M_BUSY;
                end else begin
                    chk("idle_no_cmd", cmd, 0);
                    chk("idle_ready0", m0_ready, 0);
                    chk("idle_ready1", m1_ready, 0);
                end
            end
            if (mst == M_BUSY) begin
                chk("sram_address", sram_address, cur.addr);
                chk("sram_wdata", sram_wdata, cur.wdata);
                chk("sram_write", sram_write, cur.write);
                chk("sram_read", sram_read, !cur.write);
                if (!((cur_port == 0) ? r0 : r1)) aborted = 1;
                chk("ready_granted", (cur_port == 0) ? m0_ready : m1_ready, sram_ready && !aborted);
                chk("ready_other", (cur_port == 0) ? m1_ready : m0_ready, 0);
                chk("rdata_other", (cur_port == 0) ? m1_rdata : m0_rdata, 0);
                if (sram_ready) begin
                    chk("rdata_granted", (cur_port == 0) ? m0_rdata : m1_rdata, cur.line);
                    done_cnt[cur_port]++;
                    in_grant = 0;
                    mst = M_REL;
                end
            end
            if (mst_start == M_REL) begin
                chk("release_cmd", cmd, 0);
                chk("release_ready", {m0_ready, m1_ready}, 0);
                mst = M_IDLE;
            end
            pend0 = (mst_start == M_IDLE && mst == M_IDLE) ? r0 : 1'b0;
            pend1 = (mst_start == M_IDLE && mst == M_IDLE) ? r1 : 1'b0;
        end
    end

    // Requester: raise a request, push the expectation, hold until completion; ab=1 drops in the
    // first grant cycle, ab=2 drops once the monitor sees the grant.
    task automatic do_req(input int port, input logic [31:0] addr, input logic [31:0] wd,
                          input bit wr, input bit rd, input int ab);
        exp_t e;
        int   start;
        int   t;
        bit   dropped;
        dropped = 0;
        e.addr = addr;
        e.wdata = (port == 0) ? wd : 32'h0;
        e.write = (port == 0) && wr;
        e.line = line_of(addr);
        start = done_cnt[port];
        if (port == 0) begin
            m0_address = addr;
            m0_wdata = wd;
            m0_write = wr;
            m0_read = rd | !wr;
            q0.push_back(e);
        end else begin
            m1_address = addr;
            m1_read = 1'b1;
            q1.push_back(e);
        end
        t = 0;
        while (done_cnt[port] == start && t < 300) begin
            @(posedge clk);
            #1;
            t++;
            if (!dropped && ((ab == 1 && (sram_read || sram_write)) ||
                             (ab == 2 && in_grant && cur_port == port))) begin
                dropped = 1;
                if (port == 0) begin m0_read = 1'b0; m0_write = 1'b0; end
                else m1_read = 1'b0;
            end
        end
        chk("req_timeout", t < 300, 1);
        if (port == 0) begin m0_read = 1'b0; m0_write = 1'b0; end
        else m1_read = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sram_read"}, sram_read, 0);
        chk({tag, "_sram_write"}, sram_write, 0);
        chk({tag, "_sram_address"}, sram_address, 0);
        chk({tag, "_sram_wdata"}, sram_wdata, 0);
        chk({tag, "_m0_ready"}, m0_ready, 0);
        chk({tag, "_m1_ready"}, m1_ready, 0);
        chk({tag, "_m0_rdata"}, m0_rdata, 0);
        chk({tag, "_m1_rdata"}, m1_rdata, 0);
    endtask

    initial begin : stim
        int t;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        force_dly = 3;
        do_req(1, 32'h0000_0100, 32'h0, 0, 1, 0);
        force_dly = 2;
        do_req(0, 32'h0000_0040, 32'hDEAD_BEEF, 1, 0, 0);

        force_dly = -1;
        repeat (2) begin
            @(posedge clk);
            #1;
            fork
                do_req(0, 32'h0000_1000 + ($urandom & 32'hFF8), $urandom, 0, 1, 0);
                do_req(1, 32'h0000_2000 + ($urandom & 32'hFF8), 32'h0, 0, 1, 0);
            join
        end

        force_dly = 3;
        do_req(0, 32'h0000_0300, 32'h0, 0, 1, 1);

        force_dly = -1;
        fork
            repeat (30) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                do_req(0, $urandom & 32'hFFFF_FFF8, $urandom, 1'($urandom), 1'($urandom),
                       ($urandom_range(0, 7) == 0) ? 2 : 0);
            end
            repeat (30) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                do_req(1, $urandom & 32'hFFFF_FFF8, 32'h0, 0, 1,
                       ($urandom_range(0, 7) == 0) ? 2 : 0);
            end
        join
        repeat (4) @(posedge clk);
        #1;

        force_dly = 8;
        m1_address = 32'h0000_0200;
        m1_read = 1'b1;
        q1.push_back('{addr: 32'h0000_0200, wdata: 32'h0, write: 1'b0, line: line_of(32'h0000_0200)});
        t = 0;
        while (!(sram_read || sram_write) && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("rst_test_grant", sram_read, 1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        m1_read = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("midrst");

        force_dly = 1;
        do_req(0, 32'h0000_0080, 32'h0, 0, 1, 0);
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
